// File: rtl/voice_allocator_pkg.sv
// Shared defaults and FSM encoding for the polyphonic voice allocator.
// Imported by the allocator top and its per-voice slot.
package voice_allocator_pkg;

  localparam int DEF_NUM_VOICES = 7;
  localparam int DEF_NOTE_W     = 7;
  localparam int DEF_AGE_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Voice index width; never narrower than one bit even for a single voice.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_allocator_slot.sv
// One oscillator voice: enable/note/age state plus the note compare used by the scan.
// Clear (panic) beats set, set beats release, release beats ageing.
module voice_allocator_slot
  import voice_allocator_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set,
  input  logic              rel,
  input  logic              inc,
  input  logic [NOTE_W-1:0] ev_note,
  output logic              en,
  output logic [NOTE_W-1:0] note,
  output logic [AGE_W-1:0]  age,
  output logic              match
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic              en_reg;
  logic [NOTE_W-1:0] note_reg;
  logic [AGE_W-1:0]  age_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg   <= 1'b0;
      note_reg <= '0;
      age_reg  <= '0;
    end else if (clr) begin
      en_reg  <= 1'b0;
      age_reg <= '0;
    end else if (set) begin
      en_reg   <= 1'b1;
      note_reg <= ev_note;
      age_reg  <= '0;
    end else if (rel) begin
      en_reg  <= 1'b0;
      age_reg <= '0;
    end else if (inc && en_reg && (age_reg != AGE_MAX)) begin
      // Only sounding voices age; the count saturates rather than wrapping.
      age_reg <= age_reg + 1'b1;
    end
  end

  assign en    = en_reg;
  assign note  = note_reg;
  assign age   = age_reg;
  assign match = en_reg && (note_reg == ev_note);

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: scans voices one per cycle, then commits retrigger, free-voice
// allocation or oldest-voice steal for note-on, or release for note-off.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         evValid_i,
  output logic                         evReady_o,
  input  logic                         evNoteOn_i,
  input  logic [NOTE_W-1:0]            evNote_i,
  input  logic                         panic_i,
  output logic [NUM_VOICES-1:0]        voiceEn_o,
  output logic [NUM_VOICES*NOTE_W-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]        voiceTrig_o,
  output logic                         busy_o
);

  localparam int               IDX_W    = idx_w(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t            state_reg;
  logic              ready_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              ev_on_reg;
  logic [NOTE_W-1:0] ev_note_reg;
  logic              match_found_reg, free_found_reg, old_valid_reg;
  logic [IDX_W-1:0]  match_idx_reg, free_idx_reg, old_idx_reg;
  logic [AGE_W-1:0]  old_age_reg;
  logic [NUM_VOICES-1:0] trig_reg;

  logic [NUM_VOICES-1:0] slot_en, slot_match, set_vec, rel_vec, trig_next;
  logic [AGE_W-1:0]      slot_age  [NUM_VOICES];
  logic [NOTE_W-1:0]     slot_note [NUM_VOICES];
  logic                  inc_all;
  logic [IDX_W-1:0]      alloc_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      voice_allocator_slot #(
        .NOTE_W (NOTE_W),
        .AGE_W  (AGE_W)
      ) u_slot (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (panic_i),
        .set     (set_vec[gi]),
        .rel     (rel_vec[gi]),
        .inc     (inc_all),
        .ev_note (ev_note_reg),
        .en      (slot_en[gi]),
        .note    (slot_note[gi]),
        .age     (slot_age[gi]),
        .match   (slot_match[gi])
      );
      assign voiceNote_o[gi*NOTE_W +: NOTE_W] = slot_note[gi];
    end
  endgenerate

  // Commit decoder: only active during the COMMIT cycle and suppressed by panic.
  always_comb begin
    set_vec   = '0;
    rel_vec   = '0;
    trig_next = '0;
    inc_all   = 1'b0;
    alloc_idx = free_found_reg ? free_idx_reg : old_idx_reg;
    if (state_reg == ST_COMMIT && !panic_i) begin
      if (ev_on_reg) begin
        if (match_found_reg) begin
          trig_next[match_idx_reg] = 1'b1;
        end else if (free_found_reg || old_valid_reg) begin
          set_vec[alloc_idx]   = 1'b1;
          trig_next[alloc_idx] = 1'b1;
          inc_all              = 1'b1;
        end
      end else if (match_found_reg) begin
        rel_vec[match_idx_reg] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      ready_reg       <= 1'b1;
      idx_reg         <= '0;
      ev_on_reg       <= 1'b0;
      ev_note_reg     <= '0;
      match_found_reg <= 1'b0;
      free_found_reg  <= 1'b0;
      old_valid_reg   <= 1'b0;
      match_idx_reg   <= '0;
      free_idx_reg    <= '0;
      old_idx_reg     <= '0;
      old_age_reg     <= '0;
      trig_reg        <= '0;
    end else begin
      trig_reg <= '0;
      if (panic_i) begin
        // A handshake coinciding with panic is consumed and dropped here.
        state_reg <= ST_IDLE;
        ready_reg <= 1'b1;
        idx_reg   <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // Ready returns one cycle after commit, while the trigger pulse is out.
            if (!ready_reg) begin
              ready_reg <= 1'b1;
            end else if (evValid_i) begin
              ev_on_reg       <= evNoteOn_i;
              ev_note_reg     <= evNote_i;
              match_found_reg <= 1'b0;
              free_found_reg  <= 1'b0;
              old_valid_reg   <= 1'b0;
              match_idx_reg   <= '0;
              free_idx_reg    <= '0;
              old_idx_reg     <= '0;
              old_age_reg     <= '0;
              idx_reg         <= '0;
              ready_reg       <= 1'b0;
              state_reg       <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (!match_found_reg && slot_match[idx_reg]) begin
              match_found_reg <= 1'b1;
              match_idx_reg   <= idx_reg;
            end
            if (!free_found_reg && !slot_en[idx_reg]) begin
              free_found_reg <= 1'b1;
              free_idx_reg   <= idx_reg;
            end
            // Strict compare keeps the lowest index among equally old voices.
            if (slot_en[idx_reg] && (!old_valid_reg || slot_age[idx_reg] > old_age_reg)) begin
              old_valid_reg <= 1'b1;
              old_idx_reg   <= idx_reg;
              old_age_reg   <= slot_age[idx_reg];
            end
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_COMMIT;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
          ST_COMMIT: begin
            trig_reg  <= trig_next;
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign evReady_o   = ready_reg;
  assign busy_o      = !ready_reg;
  assign voiceEn_o   = slot_en;
  assign voiceTrig_o = trig_reg;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed and random-stream checks of the voice allocator: allocation order, stealing,
// retrigger, note-off, panic, asynchronous reset and the one-voice-per-note invariant.
module tb_voice_allocator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        evValid_i = 1'b0;
  logic        evReady_o;
  logic        evNoteOn_i = 1'b0;
  logic [6:0]  evNote_i = '0;
  logic        panic_i = 1'b0;
  logic [6:0]  voiceEn_o;
  logic [48:0] voiceNote_o;
  logic [6:0]  voiceTrig_o;
  logic        busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  voice_allocator dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .evValid_i   (evValid_i),
    .evReady_o   (evReady_o),
    .evNoteOn_i  (evNoteOn_i),
    .evNote_i    (evNote_i),
    .panic_i     (panic_i),
    .voiceEn_o   (voiceEn_o),
    .voiceNote_o (voiceNote_o),
    .voiceTrig_o (voiceTrig_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog expired tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] note_of(input int i);
    return voiceNote_o[i*7 +: 7];
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    evValid_i = 1'b0;
    panic_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Issues one event and follows it until ready returns; lat counts edges after handshake.
  task automatic send_event(input logic on, input logic [6:0] note, output int lat,
                            output logic [6:0] trig_seen, output int trig_cycles);
    int waitc;
    waitc = 0;
    @(negedge clk_i);
    while (!evReady_o && waitc < 50) begin
      @(negedge clk_i);
      waitc++;
    end
    evValid_i = 1'b1;
    evNoteOn_i = on;
    evNote_i = note;
    @(posedge clk_i);
    #1;
    evValid_i = 1'b0;
    lat = 0;
    trig_seen = '0;
    trig_cycles = 0;
    do begin
      @(posedge clk_i);
      #1;
      lat++;
      if (voiceTrig_o != 0) begin
        trig_cycles++;
        trig_seen |= voiceTrig_o;
      end
    end while (!evReady_o && lat < 30);
    tests_run++;
    if (!evReady_o) begin
      tests_failed++;
      $display("FAIL ready_timeout got ready=%b after %0d cycles exp=1", evReady_o, lat);
    end
    $display("[TB] ev on=%0d note=%0d -> en=%b trig=%b lat=%0d", on, note, voiceEn_o, trig_seen, lat);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++;
    if (voiceEn_o !== 7'b0 || voiceTrig_o !== 7'b0 || voiceNote_o !== 49'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got en=%b trig=%b note=%h exp all 0", voiceEn_o, voiceTrig_o, voiceNote_o);
    end
    tests_run++;
    if (evReady_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake got ready=%b busy=%b exp 1/0", evReady_o, busy_o);
    end
  endtask

  task automatic test_single_note();
    int lat, tc;
    logic [6:0] ts;
    do_reset();
    send_event(1'b1, 7'd60, lat, ts, tc);
    tests_run++;
    if (lat !== 9) begin tests_failed++; $display("FAIL single_latency got=%0d exp=9", lat); end
    tests_run++;
    if (ts !== 7'b0000001 || tc !== 1) begin
      tests_failed++; $display("FAIL single_trig got=%b cycles=%0d exp=0000001 cycles=1", ts, tc);
    end
    tests_run++;
    if (voiceEn_o !== 7'b0000001 || note_of(0) !== 7'd60) begin
      tests_failed++; $display("FAIL single_alloc got en=%b note0=%0d exp en=0000001 note0=60", voiceEn_o, note_of(0));
    end
  endtask

  task automatic test_free_reuse();
    int lat, tc;
    logic [6:0] ts;
    do_reset();
    send_event(1'b1, 7'd60, lat, ts, tc);
    send_event(1'b1, 7'd62, lat, ts, tc);
    send_event(1'b1, 7'd64, lat, ts, tc);
    send_event(1'b0, 7'd62, lat, ts, tc);
    tests_run++;
    if (voiceEn_o !== 7'b0000101 || tc !== 0 || note_of(1) !== 7'd62) begin
      tests_failed++; $display("FAIL noteoff_release got en=%b trigcyc=%0d note1=%0d exp en=0000101 trigcyc=0 note1=62", voiceEn_o, tc, note_of(1));
    end
    send_event(1'b1, 7'd65, lat, ts, tc);
    tests_run++;
    if (voiceEn_o !== 7'b0000111 || note_of(1) !== 7'd65 || ts !== 7'b0000010) begin
      tests_failed++; $display("FAIL free_reuse got en=%b note1=%0d trig=%b exp en=0000111 note1=65 trig=0000010", voiceEn_o, note_of(1), ts);
    end
  endtask

  task automatic test_steal();
    int lat, tc;
    logic [6:0] ts;
    do_reset();
    for (int n = 60; n <= 66; n++) send_event(1'b1, 7'(n), lat, ts, tc);
    tests_run++;
    if (voiceEn_o !== 7'b1111111 || note_of(6) !== 7'd66) begin
      tests_failed++; $display("FAIL fill_all got en=%b note6=%0d exp en=1111111 note6=66", voiceEn_o, note_of(6));
    end
    send_event(1'b1, 7'd70, lat, ts, tc);
    tests_run++;
    if (note_of(0) !== 7'd70 || ts !== 7'b0000001 || voiceEn_o !== 7'b1111111 || note_of(1) !== 7'd61) begin
      tests_failed++; $display("FAIL steal_oldest got note0=%0d trig=%b en=%b note1=%0d exp 70/0000001/1111111/61", note_of(0), ts, voiceEn_o, note_of(1));
    end
    // The stolen voice restarted at age 0, so voice1 is now the oldest.
    send_event(1'b1, 7'd71, lat, ts, tc);
    tests_run++;
    if (note_of(1) !== 7'd71 || ts !== 7'b0000010 || note_of(0) !== 7'd70) begin
      tests_failed++; $display("FAIL steal_next got note1=%0d trig=%b note0=%0d exp 71/0000010/70", note_of(1), ts, note_of(0));
    end
  endtask

  task automatic test_retrigger();
    int lat, tc;
    logic [6:0] ts;
    do_reset();
    send_event(1'b1, 7'd60, lat, ts, tc);
    send_event(1'b1, 7'd62, lat, ts, tc);
    send_event(1'b1, 7'd64, lat, ts, tc);
    send_event(1'b1, 7'd64, lat, ts, tc);
    tests_run++;
    if (ts !== 7'b0000100 || tc !== 1 || voiceEn_o !== 7'b0000111) begin
      tests_failed++; $display("FAIL retrigger got trig=%b cycles=%0d en=%b exp 0000100/1/0000111", ts, tc, voiceEn_o);
    end
    send_event(1'b1, 7'd66, lat, ts, tc);
    tests_run++;
    if (voiceEn_o !== 7'b0001111 || note_of(3) !== 7'd66) begin
      tests_failed++; $display("FAIL after_retrigger got en=%b note3=%0d exp en=0001111 note3=66", voiceEn_o, note_of(3));
    end
  endtask

  task automatic test_noteoff_unknown();
    int lat, tc;
    logic [6:0] ts;
    do_reset();
    send_event(1'b1, 7'd60, lat, ts, tc);
    send_event(1'b1, 7'd62, lat, ts, tc);
    send_event(1'b1, 7'd64, lat, ts, tc);
    send_event(1'b0, 7'd50, lat, ts, tc);
    tests_run++;
    if (voiceEn_o !== 7'b0000111 || tc !== 0 || lat !== 9 ||
        note_of(0) !== 7'd60 || note_of(1) !== 7'd62 || note_of(2) !== 7'd64) begin
      tests_failed++; $display("FAIL noteoff_unknown got en=%b trigcyc=%0d lat=%0d notes=%0d,%0d,%0d exp 0000111/0/9/60,62,64",
                               voiceEn_o, tc, lat, note_of(0), note_of(1), note_of(2));
    end
  endtask

  task automatic test_panic();
    int lat, tc, trig_cnt;
    logic [6:0] ts;
    do_reset();
    send_event(1'b1, 7'd60, lat, ts, tc);
    send_event(1'b1, 7'd62, lat, ts, tc);
    @(negedge clk_i);
    evValid_i = 1'b1; evNoteOn_i = 1'b1; evNote_i = 7'd70;
    @(posedge clk_i);
    #1 evValid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    panic_i = 1'b1;
    @(posedge clk_i);
    #1;
    tests_run++;
    if (voiceEn_o !== 7'b0 || evReady_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL panic_scan got en=%b ready=%b busy=%b exp 0000000/1/0", voiceEn_o, evReady_o, busy_o);
    end
    @(negedge clk_i);
    panic_i = 1'b0;
    trig_cnt = 0;
    repeat (12) begin @(posedge clk_i); #1; if (voiceTrig_o != 0 || voiceEn_o != 0) trig_cnt++; end
    tests_run++;
    if (trig_cnt !== 0) begin tests_failed++; $display("FAIL panic_event_lost got active_cycles=%0d exp=0", trig_cnt); end
    $display("[TB] panic during scan -> en=%b ready=%b", voiceEn_o, evReady_o);
    // Panic together with a handshake: the event is swallowed.
    @(negedge clk_i);
    evValid_i = 1'b1; evNoteOn_i = 1'b1; evNote_i = 7'd71; panic_i = 1'b1;
    @(posedge clk_i);
    #1 evValid_i = 1'b0;
    @(negedge clk_i);
    panic_i = 1'b0;
    trig_cnt = 0;
    repeat (12) begin @(posedge clk_i); #1; if (voiceTrig_o != 0 || voiceEn_o != 0) trig_cnt++; end
    tests_run++;
    if (trig_cnt !== 0 || evReady_o !== 1'b1) begin
      tests_failed++; $display("FAIL panic_handshake got active_cycles=%0d ready=%b exp 0/1", trig_cnt, evReady_o);
    end
    $display("[TB] panic with handshake -> en=%b ready=%b", voiceEn_o, evReady_o);
    send_event(1'b1, 7'd61, lat, ts, tc);
    tests_run++;
    if (voiceEn_o !== 7'b0000001 || note_of(0) !== 7'd61 || ts !== 7'b0000001) begin
      tests_failed++; $display("FAIL after_panic got en=%b note0=%0d trig=%b exp 0000001/61/0000001", voiceEn_o, note_of(0), ts);
    end
  endtask

  task automatic test_async_reset();
    int lat, tc, active;
    logic [6:0] ts;
    do_reset();
    send_event(1'b1, 7'd60, lat, ts, tc);
    @(negedge clk_i);
    evValid_i = 1'b1; evNoteOn_i = 1'b1; evNote_i = 7'd62;
    @(posedge clk_i);
    #1 evValid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    tests_run++;
    if (voiceEn_o !== 7'b0 || voiceNote_o !== 49'b0 || voiceTrig_o !== 7'b0 || evReady_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset got en=%b note=%h trig=%b ready=%b busy=%b exp all reset values",
                               voiceEn_o, voiceNote_o, voiceTrig_o, evReady_o, busy_o);
    end
    $display("[TB] async reset mid-scan -> en=%b ready=%b", voiceEn_o, evReady_o);
    @(negedge clk_i);
    rst_i = 1'b0;
    active = 0;
    repeat (12) begin @(posedge clk_i); #1; if (voiceTrig_o != 0 || voiceEn_o != 0) active++; end
    tests_run++;
    if (active !== 0) begin tests_failed++; $display("FAIL no_partial_commit got active_cycles=%0d exp=0", active); end
  endtask

  task automatic test_random_invariant();
    int lat, tc, dup, present;
    logic [6:0] ts, note;
    logic on;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      note = 7'(60 + $urandom_range(0, 7));
      on = ($urandom_range(0, 2) != 0);
      send_event(on, note, lat, ts, tc);
      dup = 0;
      present = 0;
      for (int i = 0; i < 7; i++) begin
        if (voiceEn_o[i] && note_of(i) == note) present++;
        for (int j = i + 1; j < 7; j++)
          if (voiceEn_o[i] && voiceEn_o[j] && note_of(i) == note_of(j)) dup++;
      end
      tests_run++;
      if (dup !== 0) begin tests_failed++; $display("FAIL rand_dup_note ev=%0d got dups=%0d exp=0", e, dup); end
      tests_run++;
      if (present !== (on ? 1 : 0)) begin
        tests_failed++; $display("FAIL rand_presence ev=%0d on=%0d note=%0d got=%0d exp=%0d", e, on, note, present, on ? 1 : 0);
      end
      tests_run++;
      if (tc !== (on ? 1 : 0) || $countones(ts) > 1) begin
        tests_failed++; $display("FAIL rand_trig ev=%0d on=%0d got cycles=%0d trig=%b", e, on, tc, ts);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_free_reuse();
    test_steal();
    test_retrigger();
    test_noteoff_unknown();
    test_panic();
    test_async_reset();
    test_random_invariant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
